// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch/decode boundary: field positions of the
// 16-bit instruction format, two-word opcodes and the IF/ID capture states.
package isa_pkg;

  localparam int OPCODE_W = 5;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 11;
  localparam int RS_MSB    = 10;
  localparam int RS_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 5;
  localparam int SHAMT_MSB = 4;
  localparam int SHAMT_LSB = 0;

  localparam logic [OPCODE_W-1:0] OP_LDM  = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_IADD = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_LDD  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_STD  = 5'b11011;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } ifid_state_t;

  // Every opcode in the 11xxx group carries a trailing immediate word.
  function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
    return opcode[4:3] == 2'b11;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: captures fetched words, merges opcode+immediate
// pairs into one decode bundle, and honours stall/flush from hazard control.
module if_id_buffer
  import isa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_word,
  input  logic              stall,
  input  logic              flush,
  output logic              ldm_signal,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc,
  output logic [4:0]        out_opcode,
  output logic [2:0]        out_rs,
  output logic [2:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [15:0]       out_imm,
  output logic              out_has_imm
);

  ifid_state_t       state;
  logic [INST_W-1:0] held_word;
  logic [ADDR_W-1:0] held_pc;
  logic [INST_W-1:0] out_word;

  // ldm_signal is a pure state decode so fetch never sees a path from in_word.
  assign ldm_signal = (state == S_IMM);

  assign out_opcode = out_word[OP_MSB:OP_LSB];
  assign out_rs     = out_word[RS_MSB:RS_LSB];
  assign out_rd     = out_word[RD_MSB:RD_LSB];
  assign out_shamt  = out_word[SHAMT_MSB:SHAMT_LSB];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_OP;
      held_word   <= '0;
      held_pc     <= '0;
      out_valid   <= 1'b0;
      out_has_imm <= 1'b0;
      out_pc      <= '0;
      out_next_pc <= '0;
      out_word    <= '0;
      out_imm     <= '0;
    end else if (flush) begin
      // Data outputs are left stale; consumers qualify on out_valid.
      state       <= S_OP;
      held_word   <= '0;
      held_pc     <= '0;
      out_valid   <= 1'b0;
      out_has_imm <= 1'b0;
    end else if (!stall) begin
      case (state)
        S_OP: begin
          if (in_valid) begin
            if (is_two_word(in_word[OP_MSB:OP_LSB])) begin
              held_word <= in_word;
              held_pc   <= in_pc;
              out_valid <= 1'b0;
              state     <= S_IMM;
            end else begin
              out_valid   <= 1'b1;
              out_pc      <= in_pc;
              out_next_pc <= in_pc + ADDR_W'(1);
              out_word    <= in_word;
              out_imm     <= '0;
              out_has_imm <= 1'b0;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        S_IMM: begin
          // The word arriving here is data, never an opcode.
          if (in_valid) begin
            out_valid   <= 1'b1;
            out_pc      <= held_pc;
            out_next_pc <= held_pc + ADDR_W'(2);
            out_word    <= held_word;
            out_imm     <= in_word;
            out_has_imm <= 1'b1;
            state       <= S_OP;
          end else begin
            out_valid <= 1'b0;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed words push expected bundles,
// a negedge monitor pops and compares each newly presented bundle.
module tb_if_id_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [4:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        has_imm;
  } bundle_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [15:0] in_word;
  logic        stall;
  logic        flush;
  logic        ldm_signal;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic [4:0]  out_opcode;
  logic [2:0]  out_rs;
  logic [2:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [15:0] out_imm;
  logic        out_has_imm;

  int total = 0;
  int bad   = 0;
  bundle_t expected_q[$];
  logic edge_was_held = 1'b0;

  if_id_buffer #(.ADDR_W(32), .INST_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_word    (in_word),
    .stall      (stall),
    .flush      (flush),
    .ldm_signal (ldm_signal),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_next_pc(out_next_pc),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt),
    .out_imm    (out_imm),
    .out_has_imm(out_has_imm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A stalled edge re-presents the old bundle, which must not be popped again.
  always @(posedge clk) edge_was_held <= stall && !flush;

  always @(negedge clk) begin
    bundle_t act;
    bundle_t exp_b;
    if (reset && out_valid && !edge_was_held) begin
      act = '{out_pc, out_next_pc, out_opcode, out_rs, out_rd, out_shamt, out_imm, out_has_imm};
      total++;
      if (expected_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_bundle: got %h, none expected", act);
      end else begin
        exp_b = expected_q.pop_front();
        if (act !== exp_b) begin
          bad++;
          $display("[TB] FAIL bundle: got %h required %h", act, exp_b);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, required);
    end
  endtask

  task automatic expectBundle(input logic [31:0] pc, input logic [31:0] next_pc,
                              input logic [4:0] opcode, input logic [2:0] rs,
                              input logic [2:0] rd, input logic [4:0] shamt,
                              input logic [15:0] imm, input logic has_imm);
    expected_q.push_back('{pc, next_pc, opcode, rs, rd, shamt, imm, has_imm});
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [15:0] word,
                               input logic stl, input logic fl);
    in_valid = valid;
    in_pc    = pc;
    in_word  = word;
    stall    = stl;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_pc    = '0;
    in_word  = '0;
    stall    = 1'b0;
    flush    = 1'b0;

    #12;
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_ldm", {31'd0, ldm_signal}, 32'd0);
    checkOutput("reset_pc", out_pc, 32'd0);
    checkOutput("reset_imm", {16'd0, out_imm}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // One-word instruction, latency 1
    expectBundle(32'h20, 32'h21, 5'b00001, 3'd2, 3'd2, 5'd5, 16'h0, 1'b0);
    applyStimulus(1'b1, 32'h20, 16'h0A45, 1'b0, 1'b0);
    checkOutput("oneword_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("oneword_ldm", {31'd0, ldm_signal}, 32'd0);

    // LDM + immediate back to back
    applyStimulus(1'b1, 32'h21, 16'hC020, 1'b0, 1'b0);
    checkOutput("ldm_bubble_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("ldm_wait_ldm", {31'd0, ldm_signal}, 32'd1);
    expectBundle(32'h21, 32'h23, 5'b11000, 3'd0, 3'd1, 5'd0, 16'h1234, 1'b1);
    applyStimulus(1'b1, 32'h22, 16'h1234, 1'b0, 1'b0);
    checkOutput("ldm_done_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("ldm_done_ldm", {31'd0, ldm_signal}, 32'd0);

    // LDM with a three-cycle fetch gap
    applyStimulus(1'b1, 32'h30, 16'hC020, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h31, 16'hFFFF, 1'b0, 1'b0);
      checkOutput("gap_ldm", {31'd0, ldm_signal}, 32'd1);
      checkOutput("gap_valid", {31'd0, out_valid}, 32'd0);
    end
    expectBundle(32'h30, 32'h32, 5'b11000, 3'd0, 3'd1, 5'd0, 16'hBEEF, 1'b1);
    applyStimulus(1'b1, 32'h31, 16'hBEEF, 1'b0, 1'b0);

    // Flush beats stall while waiting for an immediate
    applyStimulus(1'b1, 32'h40, 16'hC020, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h41, 16'h5555, 1'b1, 1'b1);
    checkOutput("flush_ldm", {31'd0, ldm_signal}, 32'd0);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b1, 32'h42, 16'hC0FF, 1'b0, 1'b0);
    checkOutput("post_flush_ldm", {31'd0, ldm_signal}, 32'd1);
    checkOutput("post_flush_valid", {31'd0, out_valid}, 32'd0);
    expectBundle(32'h42, 32'h44, 5'b11000, 3'd0, 3'd7, 5'd31, 16'h00AA, 1'b1);
    applyStimulus(1'b1, 32'h43, 16'h00AA, 1'b0, 1'b0);

    // Stall holds a valid bundle for two cycles
    expectBundle(32'h50, 32'h51, 5'b00100, 3'd3, 3'd2, 5'd5, 16'h0, 1'b0);
    applyStimulus(1'b1, 32'h50, 16'h2345, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h51, 16'hC111, 1'b1, 1'b0);
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_pc", out_pc, 32'h50);
      checkOutput("stall_opcode", {27'd0, out_opcode}, 32'd4);
      checkOutput("stall_ldm", {31'd0, ldm_signal}, 32'd0);
    end
    expectBundle(32'h51, 32'h52, 5'b00001, 3'd0, 3'd2, 5'd1, 16'h0, 1'b0);
    applyStimulus(1'b1, 32'h51, 16'h0841, 1'b0, 1'b0);

    // Asynchronous reset while in S_IMM
    applyStimulus(1'b1, 32'h60, 16'hC020, 1'b0, 1'b0);
    checkOutput("pre_reset_ldm", {31'd0, ldm_signal}, 32'd1);
    applyStimulus(1'b0, 32'h61, 16'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_ldm", {31'd0, ldm_signal}, 32'd0);
    checkOutput("async_reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_reset_pc", out_pc, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    expectBundle(32'h70, 32'h71, 5'b00010, 3'd2, 3'd1, 5'd20, 16'h0, 1'b0);
    applyStimulus(1'b1, 32'h70, 16'h1234, 1'b0, 1'b0);
    checkOutput("post_reset_ldm", {31'd0, ldm_signal}, 32'd0);

    // PC wrap for two-word and one-word instructions
    applyStimulus(1'b1, 32'hFFFF_FFFF, 16'hC8AB, 1'b0, 1'b0);
    expectBundle(32'hFFFF_FFFF, 32'h1, 5'b11001, 3'd0, 3'd5, 5'd11, 16'h7777, 1'b1);
    applyStimulus(1'b1, 32'h0, 16'h7777, 1'b0, 1'b0);
    expectBundle(32'hFFFF_FFFF, 32'h0, 5'b00001, 3'd2, 3'd2, 5'd5, 16'h0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 16'h0A45, 1'b0, 1'b0);

    applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 10 && expected_q.size() != 0; i++) @(posedge clk);
    total++;
    if (expected_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending bundles required 0", expected_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
